// File: rtl/mem_stage_arb_pkg.sv
// Shared types and defaults for the memory-stage arbiter: lane request/commit
// records, the FSM state encoding and the default bundle geometry.
package mem_stage_arb_pkg;

    localparam int DEF_LANES  = 2;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam int REG_ADDR_W = 5;

    typedef struct packed {
        logic                  read_ena;
        logic                  write_ena;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] result;
        logic                  write_reg_need;
        logic [REG_ADDR_W-1:0] write_reg_addr;
    } mem_require_t;

    typedef struct packed {
        logic [DEF_DATA_W-1:0] result;
        logic                  write_reg_need;
        logic [REG_ADDR_W-1:0] write_reg_addr;
    } cmt_require_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_ACK,
        ST_DONE
    } state_t;

    function automatic int lane_idx_w(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/mem_stage_arb_lane_pick.sv
// Priority encoder: lowest pending memory lane whose index is >= start,
// with a none flag when no such lane remains.
module mem_lane_pick
    import mem_stage_arb_pkg::*;
#(
    parameter int LANES = DEF_LANES,
    parameter int IDX_W = lane_idx_w(LANES)
) (
    input  logic [LANES-1:0] pending,
    input  logic [IDX_W-1:0] start,
    output logic [IDX_W-1:0] lane,
    output logic             none
);

    logic [LANES-1:0] eligible;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_elig
        assign eligible[gi] = pending[gi] && (gi >= int'(start));
    end

    // Scan downward so the lowest eligible lane wins.
    always_comb begin
        lane = '0;
        none = 1'b1;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                lane = IDX_W'(i);
                none = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mem_stage_arb.sv
// Memory stage: holds one issue bundle, walks its memory lanes in ascending
// order through a single-outstanding cache port, then presents the results.
module mem_stage_arb
    import mem_stage_arb_pkg::*;
#(
    parameter int LANES  = DEF_LANES,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  mem_require_t       mem_require [0:LANES-1],
    input  logic               flush,
    output logic               stall,
    output logic               cache_req,
    output logic               cache_we,
    output logic [ADDR_W-1:0]  cache_addr,
    output logic [DATA_W-1:0]  cache_wdata,
    input  logic               cache_ack,
    input  logic [DATA_W-1:0]  cache_rdata,
    output logic               out_valid,
    output cmt_require_t       cmt_require [0:LANES-1]
);

    localparam int IDX_W = lane_idx_w(LANES);

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   lane_idx_reg, lane_idx_next;
    logic [LANES-1:0]   pending_reg, pending_next;
    logic               flush_reg, flush_next;

    logic                  lane_we_reg   [LANES];
    logic [DEF_ADDR_W-1:0] lane_addr_reg [LANES];
    logic [DEF_DATA_W-1:0] lane_data_reg [LANES];
    cmt_require_t          cmt_reg       [LANES];

    logic [LANES-1:0]   in_mask;
    logic [LANES-1:0]   pending_clr;
    logic [LANES-1:0]   pick_pending;
    logic [IDX_W-1:0]   pick_start;
    logic [IDX_W-1:0]   pick_lane;
    logic               pick_none;
    logic               accept;
    logic               ack_take;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign in_mask[gi]     = mem_require[gi].read_ena | mem_require[gi].write_ena;
        assign cmt_require[gi] = cmt_reg[gi];
    end

    assign pending_clr = pending_reg & ~(LANES'(1) << lane_idx_reg);

    // One encoder serves both the first pick at acceptance and the advance on ack.
    assign pick_pending = (state_reg == ST_IDLE) ? in_mask : pending_clr;
    assign pick_start   = (state_reg == ST_IDLE) ? '0 : lane_idx_reg;

    mem_lane_pick #(
        .LANES (LANES),
        .IDX_W (IDX_W)
    ) u_pick (
        .pending (pick_pending),
        .start   (pick_start),
        .lane    (pick_lane),
        .none    (pick_none)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            lane_idx_reg <= '0;
            pending_reg  <= '0;
            flush_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            lane_idx_reg <= lane_idx_next;
            pending_reg  <= pending_next;
            flush_reg    <= flush_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LANES; i++) begin
                lane_we_reg[i]   <= 1'b0;
                lane_addr_reg[i] <= '0;
                lane_data_reg[i] <= '0;
                cmt_reg[i]       <= '0;
            end
        end else if (accept) begin
            for (int i = 0; i < LANES; i++) begin
                lane_we_reg[i]            <= mem_require[i].write_ena;
                lane_addr_reg[i]          <= mem_require[i].addr;
                lane_data_reg[i]          <= mem_require[i].result;
                cmt_reg[i].result         <= mem_require[i].result;
                cmt_reg[i].write_reg_need <= mem_require[i].write_reg_need;
                cmt_reg[i].write_reg_addr <= mem_require[i].write_reg_addr;
            end
        end else if (ack_take) begin
            // Only loads write back; a store keeps its issued record.
            for (int i = 0; i < LANES; i++) begin
                if (IDX_W'(i) == lane_idx_reg && !lane_we_reg[i]) begin
                    cmt_reg[i].result <= DEF_DATA_W'(cache_rdata);
                end
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        lane_idx_next = lane_idx_reg;
        pending_next  = pending_reg;
        flush_next    = flush_reg;
        accept        = 1'b0;
        ack_take      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (in_valid && !flush) begin
                    accept       = 1'b1;
                    pending_next = in_mask;
                    flush_next   = 1'b0;
                    if (pick_none) begin
                        state_next = ST_DONE;
                    end else begin
                        state_next    = ST_ISSUE;
                        lane_idx_next = pick_lane;
                    end
                end
            end
            ST_ISSUE, ST_WAIT_ACK: begin
                if (cache_ack) begin
                    ack_take     = 1'b1;
                    pending_next = pending_clr;
                    if (flush || flush_reg) begin
                        state_next    = ST_IDLE;
                        flush_next    = 1'b0;
                        lane_idx_next = '0;
                        pending_next  = '0;
                    end else if (pick_none) begin
                        state_next = ST_DONE;
                    end else begin
                        state_next    = ST_ISSUE;
                        lane_idx_next = pick_lane;
                    end
                end else begin
                    // A flush here only takes effect once the open access is acked.
                    if (state_reg == ST_ISSUE) state_next = ST_WAIT_ACK;
                    if (flush) flush_next = 1'b1;
                end
            end
            ST_DONE: begin
                state_next    = ST_IDLE;
                lane_idx_next = '0;
                pending_next  = '0;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        stall       = (state_reg != ST_IDLE);
        cache_req   = (state_reg == ST_ISSUE) || (state_reg == ST_WAIT_ACK);
        cache_we    = cache_req && lane_we_reg[lane_idx_reg];
        cache_addr  = cache_req ? ADDR_W'(lane_addr_reg[lane_idx_reg]) : '0;
        cache_wdata = cache_req ? DATA_W'(lane_data_reg[lane_idx_reg]) : '0;
        out_valid   = (state_reg == ST_DONE) && !flush;
    end

endmodule
